// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder for the K=3, rate-1/2, generators 7/5 code.
// Register-exchange survivors of TB_DEPTH bits, single-cycle ACS per symbol,
// FILL/RUN/DRAIN control with a flush request that drains buffered bits.
// Optional macro VITERBI_ZERO_TAIL_EN: drain from the state-00 survivor
// (zero-tail terminated streams) instead of the best-metric state.
module viterbi_decoder #(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       in_valid,
  input  logic [1:0] parities,
  output logic       in_ready,
  input  logic       flush,
  output logic       out_valid,
  output logic       out_bit,
  output logic       busy
);

  localparam int CNT_W = $clog2(TB_DEPTH + 1);
  localparam int SUM_W = PM_W + 1;
  localparam logic [PM_W-1:0] PM_INIT = PM_W'(4);

  typedef enum logic [1:0] {FILL, RUN, DRAIN} state_t;

  state_t state, state_nxt;

  logic [PM_W-1:0]     pm       [4];
  logic [TB_DEPTH-1:0] path     [4];
  logic [SUM_W-1:0]    m_lo     [4];
  logic [SUM_W-1:0]    m_hi     [4];
  logic [SUM_W-1:0]    sum      [4];
  logic                sel_hi   [4];
  logic [PM_W-1:0]     pm_new   [4];
  logic [TB_DEPTH-1:0] path_pre [4];
  logic [TB_DEPTH-1:0] path_new [4];
  logic [SUM_W-1:0]    sum_min;
  logic [1:0]          best_new;
  logic [TB_DEPTH-1:0] src_new, src_cur, drain_path;
  logic [CNT_W-1:0]    cnt;
  logic                drain_bit;
  logic                accept;

  // Hamming distance between received and expected code symbols (0..2).
  function automatic logic [SUM_W-1:0] branch_metric(input logic [1:0] rx,
                                                     input logic [1:0] expd);
    logic [1:0] d;
    d = rx ^ expd;
    return SUM_W'(d[1]) + SUM_W'(d[0]);
  endfunction

  // Clamp a normalised metric to the register width.
  function automatic logic [PM_W-1:0] sat_pm(input logic [SUM_W-1:0] v);
    if (v > SUM_W'({PM_W{1'b1}})) return {PM_W{1'b1}};
    return v[PM_W-1:0];
  endfunction

  assign in_ready = (state != DRAIN);
  assign busy     = (state == DRAIN);
  assign accept   = in_valid & in_ready;

  // Add-compare-select: new state {a,b} comes from {0,a} or {1,a}; ties keep {0,a}.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      m_lo[i]     = SUM_W'(pm[{1'b0, i[1]}]) + branch_metric(parities, {i[0] ^ i[1], i[0]});
      m_hi[i]     = SUM_W'(pm[{1'b1, i[1]}]) + branch_metric(parities, {~(i[0] ^ i[1]), ~i[0]});
      sel_hi[i]   = (m_hi[i] < m_lo[i]);
      sum[i]      = sel_hi[i] ? m_hi[i] : m_lo[i];
      path_pre[i] = sel_hi[i] ? path[{1'b1, i[1]}] : path[{1'b0, i[1]}];
      path_new[i] = {path_pre[i][TB_DEPTH-2:0], i[0]};
    end
  end

  // Normalise new metrics by their minimum; strict compare keeps the lowest index on ties.
  always_comb begin
    sum_min  = sum[0];
    best_new = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (sum[i] < sum_min) begin
        sum_min  = sum[i];
        best_new = 2'(i);
      end
    end
    for (int i = 0; i < 4; i++) pm_new[i] = sat_pm(sum[i] - sum_min);
  end

`ifdef VITERBI_ZERO_TAIL_EN
  assign src_new = path_new[0];
  assign src_cur = path[0];
`else
  logic [1:0] best_cur;

  // Best state among the stored metrics, used when flush arrives without a symbol.
  always_comb begin
    best_cur = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (pm[i] < pm[best_cur]) best_cur = 2'(i);
    end
  end

  assign src_new = path_new[best_new];
  assign src_cur = path[best_cur];
`endif

  // Oldest still-buffered bit of the latched drain path sits at position cnt-1.
  always_comb begin
    drain_bit = 1'b0;
    for (int i = 0; i < TB_DEPTH; i++) begin
      if (CNT_W'(i) == cnt - 1'b1) drain_bit = drain_path[i];
    end
  end

  // Control state register.
  always_ff @(posedge CLK) begin
    if (RST) state <= FILL;
    else     state <= state_nxt;
  end

  // Next-state logic: flush wins over FILL->RUN; DRAIN ends on its last bit (or at once if empty).
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        if (flush)                                        state_nxt = DRAIN;
        else if (accept && cnt == CNT_W'(TB_DEPTH - 1))   state_nxt = RUN;
      end
      RUN:     if (flush) state_nxt = DRAIN;
      DRAIN:   if (cnt <= CNT_W'(1)) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Metrics, survivors, symbol count, drain latch and registered output.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) begin
        pm[i]   <= (i == 0) ? '0 : PM_INIT;
        path[i] <= '0;
      end
      cnt        <= '0;
      drain_path <= '0;
      out_valid  <= 1'b0;
      out_bit    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        for (int i = 0; i < 4; i++) begin
          pm[i]   <= pm_new[i];
          path[i] <= path_new[i];
        end
        if (state == RUN) begin
          out_valid <= 1'b1;
          out_bit   <= path_pre[best_new][TB_DEPTH-1];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (flush && state != DRAIN) drain_path <= accept ? src_new : src_cur;
      if (state == DRAIN) begin
        if (cnt != '0) begin
          out_valid <= 1'b1;
          out_bit   <= drain_bit;
          cnt       <= cnt - 1'b1;
        end
        if (cnt <= CNT_W'(1)) begin
          for (int i = 0; i < 4; i++) begin
            pm[i]   <= (i == 0) ? '0 : PM_INIT;
            path[i] <= '0;
          end
          cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Scoreboard bench for viterbi_decoder: a TB_DEPTH=4 instance for the short
// directed streams and a TB_DEPTH=16 instance for the long all-zero stream.
module tb_viterbi_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid4, flush4, in_ready4, out_valid4, out_bit4, busy4;
  logic [1:0] par4;
  logic       in_valid16, flush16, in_ready16, out_valid16, out_bit16, busy16;
  logic [1:0] par16;

  viterbi_decoder #(.TB_DEPTH(4)) u4 (
    .CLK(clk), .RST(rst), .in_valid(in_valid4), .parities(par4), .in_ready(in_ready4),
    .flush(flush4), .out_valid(out_valid4), .out_bit(out_bit4), .busy(busy4)
  );

  viterbi_decoder #(.TB_DEPTH(16)) u16 (
    .CLK(clk), .RST(rst), .in_valid(in_valid16), .parities(par16), .in_ready(in_ready16),
    .flush(flush16), .out_valid(out_valid16), .out_bit(out_bit16), .busy(busy16)
  );

  logic q4[$];
  logic q16[$];
  int   vectors = 0;
  int   errors  = 0;
  int   acc16   = 0;
  int   n16     = 0;
  bit   seen16  = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor for the depth-4 decoder.
  always @(negedge clk) begin
    logic e;
    if (out_valid4) begin
      if (q4.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL u4 unexpected out_valid: got bit %0d, expected no output", out_bit4);
      end else begin
        e = q4.pop_front();
        check("u4 out_bit", int'(out_bit4), int'(e));
      end
    end
  end

  // Scoreboard monitor for the depth-16 decoder, including first-output latency.
  always @(negedge clk) begin
    logic e;
    if (out_valid16) begin
      n16++;
      if (!seen16) begin
        seen16 = 1;
        check("u16 accepts before first output", acc16, 17);
      end
      if (q16.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL u16 unexpected out_valid: got bit %0d, expected no output", out_bit16);
      end else begin
        e = q16.pop_front();
        check("u16 out_bit", int'(out_bit16), int'(e));
      end
    end
  end

  task automatic push4(input logic [7:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) q4.push_back(bits[k]);
  endtask

  task automatic send4(input logic [1:0] p, input logic fl);
    in_valid4 = 1'b1;
    par4      = p;
    flush4    = fl;
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    flush4    = 1'b0;
  endtask

  // Symbols packed first-in-MSB, two bits each.
  task automatic seq4(input logic [11:0] syms, input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      send4(syms[11-2*k -: 2], 1'b0);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
        check("u4 in_ready during gap", int'(in_ready4), 1);
      end
    end
  endtask

  task automatic flush_wait4(input int cycles);
    flush4 = 1'b1;
    @(posedge clk);
    #1;
    flush4 = 1'b0;
    check("u4 busy in DRAIN", int'(busy4), 1);
    check("u4 in_ready in DRAIN", int'(in_ready4), 0);
    repeat (cycles) @(posedge clk);
    #1;
    check("u4 busy after DRAIN", int'(busy4), 0);
    check("u4 pending outputs", q4.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid4 = 1'b0; par4 = 2'b00; flush4 = 1'b0;
    in_valid16 = 1'b0; par16 = 2'b00; flush16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset out_valid", int'(out_valid4), 0);
    check("reset out_bit", int'(out_bit4), 0);
    check("reset busy", int'(busy4), 0);
    check("reset in_ready", int'(in_ready4), 1);
    check("reset u16 in_ready", int'(in_ready16), 1);

    // 40 all-zero symbols on the depth-16 decoder: 24 zeros before flush, 16 in DRAIN.
    for (int k = 0; k < 40; k++) q16.push_back(1'b0);
    for (int k = 0; k < 40; k++) begin
      in_valid16 = 1'b1;
      par16      = 2'b00;
      @(posedge clk);
      #1;
      acc16++;
    end
    in_valid16 = 1'b0;
    flush16 = 1'b1;
    @(posedge clk);
    #1;
    flush16 = 1'b0;
    check("u16 outputs before flush", n16, 24);
    check("u16 busy in DRAIN", int'(busy16), 1);
    check("u16 in_ready in DRAIN", int'(in_ready16), 0);
    repeat (18) @(posedge clk);
    #1;
    check("u16 total outputs", n16, 40);
    check("u16 busy after DRAIN", int'(busy16), 0);

    // Clean stream 11,10,00,01,01,11 -> 1,0,1,1,0,0.
    push4(8'b00101100, 6);
    seq4(12'b11_10_00_01_01_11, 6, 0);
    flush_wait4(6);

    // Second symbol corrupted 10 -> 11, same decode.
    push4(8'b00101100, 6);
    seq4(12'b11_11_00_01_01_11, 6, 0);
    flush_wait4(6);

    // Gapped input, one symbol every third cycle.
    push4(8'b00101100, 6);
    seq4(12'b11_10_00_01_01_11, 6, 2);
    flush_wait4(6);

    // Stream ending 1,1 without tail.
`ifdef VITERBI_ZERO_TAIL_EN
    push4(8'b00001000, 4);
`else
    push4(8'b00001011, 4);
`endif
    seq4(12'b11_10_00_01_00_00, 4, 0);
    flush_wait4(6);

    // Partial buffer: two symbols then flush.
`ifdef VITERBI_ZERO_TAIL_EN
    push4(8'b00000000, 2);
`else
    push4(8'b00000010, 2);
`endif
    seq4(12'b11_10_00_00_00_00, 2, 0);
    flush_wait4(4);

    // Flush together with the third accept: symbol taken, then DRAIN of 3 bits.
`ifdef VITERBI_ZERO_TAIL_EN
    push4(8'b00000100, 3);
`else
    push4(8'b00000101, 3);
`endif
    seq4(12'b11_10_00_00_00_00, 2, 0);
    send4(2'b00, 1'b1);
    check("u4 busy after flush+accept", int'(busy4), 1);
    repeat (5) @(posedge clk);
    #1;
    check("u4 pending after flush+accept", q4.size(), 0);

    // Empty drain: one busy cycle, no output.
    flush_wait4(1);

    // Reset after two drain bits, then a fresh stream.
    push4(8'b00001011, 4);
    seq4(12'b11_10_00_01_01_11, 6, 0);
    flush4 = 1'b1;
    @(posedge clk);
    #1;
    flush4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst mid-DRAIN out_valid", int'(out_valid4), 0);
    check("rst mid-DRAIN busy", int'(busy4), 0);
    check("rst mid-DRAIN in_ready", int'(in_ready4), 1);
    check("rst mid-DRAIN pending", q4.size(), 0);
    rst = 1'b0;
    push4(8'b00101100, 6);
    seq4(12'b11_10_00_01_01_11, 6, 0);
    flush_wait4(6);

    check("u16 pending outputs", q16.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
